// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: opens a timed five-voter ballot session, accepts one vote
// per voter, then freezes and presents the ballot until the next session.
module vote_session_ctrl #(
  parameter int unsigned WINDOW = 1000,
  parameter int unsigned CW     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] cast,
  input  logic [4:0] vote,
  output logic [4:0] comps,
  output logic [4:0] voted,
  output logic       busy,
  output logic       result_valid,
  output logic       done,
  output logic       timeout,
  output logic [2:0] yes_count,
  output logic       majority
);

  localparam int unsigned NV = 5;
  localparam logic [NV-1:0] ALL_VOTED = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_OPEN   = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   timer_q, timer_d;
  logic [NV-1:0]   ballot_q, ballot_d;
  logic [NV-1:0]   voted_q, voted_d;
  logic [NV-1:0]   comps_q, comps_d;
  logic [2:0]      yes_q, yes_d;
  logic            maj_q, maj_d;
  logic            timeout_q, timeout_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            rv_q, rv_d;

  logic [NV-1:0]   accept;
  logic [NV-1:0]   final_voted;
  logic [NV-1:0]   final_ballot;
  logic [2:0]      final_yes;

  // Number of yes bits in a ballot.
  function automatic logic [2:0] popcnt5(input logic [NV-1:0] v);
    logic [2:0] s;
    s = '0;
    for (int unsigned i = 0; i < NV; i++) begin
      s = s + 3'(v[i]);
    end
    return s;
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    ballot_d     = ballot_q;
    voted_d      = voted_q;
    comps_d      = comps_q;
    yes_d        = yes_q;
    maj_d        = maj_q;
    timeout_d    = timeout_q;
    done_d       = 1'b0;
    accept       = '0;
    final_voted  = voted_q;
    final_ballot = ballot_q;
    final_yes    = '0;

    case (state_q)
      S_IDLE, S_RESULT: begin
        if (start) begin
          state_d   = S_OPEN;
          timer_d   = CW'(WINDOW - 1);
          ballot_d  = '0;
          voted_d   = '0;
          comps_d   = '0;
          yes_d     = '0;
          maj_d     = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_OPEN: begin
        // First vote per voter is final; later casts from that voter are dropped.
        accept       = cast & ~voted_q;
        final_voted  = voted_q | accept;
        final_ballot = (ballot_q & ~accept) | (vote & accept);
        final_yes    = popcnt5(final_ballot);
        voted_d      = final_voted;
        ballot_d     = final_ballot;
        if ((final_voted == ALL_VOTED) || (timer_q == '0)) begin
          state_d   = S_RESULT;
          comps_d   = final_ballot;
          yes_d     = final_yes;
          maj_d     = (final_yes >= 3'd3);
          done_d    = 1'b1;
          timeout_d = (timer_q == '0) && (final_voted != ALL_VOTED);
        end else begin
          timer_d = timer_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_OPEN);
    rv_d   = (state_d == S_RESULT);
  end

  // State and output registers; reset discards any session in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      ballot_q  <= '0;
      voted_q   <= '0;
      comps_q   <= '0;
      yes_q     <= '0;
      maj_q     <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ballot_q  <= ballot_d;
      voted_q   <= voted_d;
      comps_q   <= comps_d;
      yes_q     <= yes_d;
      maj_q     <= maj_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      rv_q      <= rv_d;
    end
  end

  assign comps        = comps_q;
  assign voted        = voted_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign yes_count    = yes_q;
  assign majority     = maj_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl: stimulus pushes expected results, a monitor
// checks them on every done pulse. Two instances (WINDOW=8 and WINDOW=4)
// share the stimulus; sel picks which one is observed.
module tb_vote_session_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] cast;
  logic [4:0] vote;
  logic       sel;

  logic [4:0] comps8, voted8, comps4, voted4;
  logic [2:0] yes8, yes4;
  logic       busy8, rv8, done8, to8, maj8;
  logic       busy4, rv4, done4, to4, maj4;

  logic [4:0] comps_s, voted_s;
  logic [2:0] yes_s;
  logic       busy_s, rv_s, done_s, to_s, maj_s;

  int checks;
  int errors;
  int cyc;

  typedef struct {
    logic [4:0] comps;
    logic [4:0] voted;
    logic [2:0] yes;
    logic       maj;
    logic       to;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  vote_session_ctrl #(.WINDOW(8), .CW(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .cast(cast), .vote(vote),
    .comps(comps8), .voted(voted8), .busy(busy8), .result_valid(rv8),
    .done(done8), .timeout(to8), .yes_count(yes8), .majority(maj8)
  );

  vote_session_ctrl #(.WINDOW(4), .CW(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .cast(cast), .vote(vote),
    .comps(comps4), .voted(voted4), .busy(busy4), .result_valid(rv4),
    .done(done4), .timeout(to4), .yes_count(yes4), .majority(maj4)
  );

  assign comps_s = sel ? comps4 : comps8;
  assign voted_s = sel ? voted4 : voted8;
  assign yes_s   = sel ? yes4   : yes8;
  assign busy_s  = sel ? busy4  : busy8;
  assign rv_s    = sel ? rv4    : rv8;
  assign done_s  = sel ? done4  : done8;
  assign to_s    = sel ? to4    : to8;
  assign maj_s   = sel ? maj4   : maj8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] c, input logic [4:0] v, input logic [2:0] y,
                      input logic m, input logic t, input int at);
    exp_t e;
    e.comps = c; e.voted = v; e.yes = y; e.maj = m; e.to = t; e.cyc = at;
    sb.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done_s) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("comps", int'(comps_s), int'(e.comps));
        check("voted", int'(voted_s), int'(e.voted));
        check("yes_count", int'(yes_s), int'(e.yes));
        check("majority", int'(maj_s), int'(e.maj));
        check("timeout", int'(to_s), int'(e.to));
        check("rv_at_done", int'(rv_s), 1);
        check("busy_at_done", int'(busy_s), 0);
      end
    end
  end

  // Wait for the expectation queue to drain; bounded.
  task automatic drain(input int max);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      if (busy_s) check("comps_zero_open", int'(comps_s), 0);
      tick();
      n++;
    end
    #5;
    if (sb.size() != 0) begin
      check("result_timeout", 0, 1);
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_comps"}, int'(comps_s), 0);
    check({name, "_voted"}, int'(voted_s), 0);
    check({name, "_busy"}, int'(busy_s), 0);
    check({name, "_rv"}, int'(rv_s), 0);
    check({name, "_done"}, int'(done_s), 0);
    check({name, "_timeout"}, int'(to_s), 0);
    check({name, "_yes"}, int'(yes_s), 0);
    check({name, "_maj"}, int'(maj_s), 0);
  endtask

  initial begin
    int k;
    checks = 0; errors = 0; cyc = 0;
    sel = 1'b0; rst_n = 1'b0; start = 1'b0; cast = '0; vote = '0;
    tick(); tick();
    rst_n = 1'b1;
    check_all_zero("reset");

    // Full ballot in the first OPEN cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy", int'(busy_s), 1);
    cast = 5'b11111; vote = 5'b10110;
    push(5'b10110, 5'b11111, 3'd3, 1'b1, 1'b0, cyc + 1);
    tick();
    cast = '0; vote = '0;
    drain(4);
    tick();
    check("t1_done_one_cycle", int'(done_s), 0);
    check("t1_rv_held", int'(rv_s), 1);
    check("t1_comps_held", int'(comps_s), 5'b10110);

    // Window expiry with two voters; start pulse mid-OPEN must not disturb timer.
    start = 1'b1;
    tick();
    start = 1'b0;
    k = cyc;
    check("t2_comps_cleared", int'(comps_s), 0);
    push(5'b00101, 5'b00101, 3'd2, 1'b0, 1'b1, k + 8);
    cast = 5'b00101; vote = 5'b00101;
    tick();
    cast = '0; vote = '0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    drain(20);

    // Repeat cast ignored; comps stays 0 while open.
    start = 1'b1;
    tick();
    start = 1'b0;
    k = cyc;
    push(5'b00010, 5'b11111, 3'd1, 1'b0, 1'b0, k + 5);
    cast = 5'b00010; vote = 5'b00010;
    tick();
    cast = '0; vote = '0;
    check("t3_comps_open", int'(comps_s), 0);
    tick();
    check("t3_comps_open", int'(comps_s), 0);
    tick();
    cast = 5'b00010; vote = 5'b00000;
    tick();
    check("t3_comps_open", int'(comps_s), 0);
    check("t3_voted_mid", int'(voted_s), 5'b00010);
    cast = 5'b11101; vote = 5'b00000;
    tick();
    cast = '0;
    drain(4);

    // Start in RESULT clears outputs on the next edge.
    start = 1'b1;
    tick();
    check("rs_comps", int'(comps_s), 0);
    check("rs_voted", int'(voted_s), 0);
    check("rs_yes", int'(yes_s), 0);
    check("rs_busy", int'(busy_s), 1);
    check("rs_rv", int'(rv_s), 0);
    // Start held high: complete the ballot, RESULT lasts one cycle then re-opens.
    cast = 5'b11111; vote = 5'b11111;
    push(5'b11111, 5'b11111, 3'd5, 1'b1, 1'b0, cyc + 1);
    tick();
    cast = '0; vote = '0;
    drain(4);
    tick();
    check("held_busy", int'(busy_s), 1);
    check("held_done", int'(done_s), 0);
    check("held_comps", int'(comps_s), 0);
    start = 1'b0;

    // Async reset two cycles into OPEN after three casts.
    cast = 5'b00111; vote = 5'b00111;
    tick();
    cast = '0; vote = '0;
    check("pre_rst_voted", int'(voted_s), 5'b00111);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    rst_n = 1'b1;
    cast = 5'b11111; vote = 5'b11111;
    tick();
    tick();
    cast = '0; vote = '0;
    check_all_zero("idle_cast");

    // WINDOW=4: final voters cast in the timer==0 cycle.
    sel = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = cyc;
    push(5'b10101, 5'b11111, 3'd3, 1'b1, 1'b0, k + 4);
    cast = 5'b00011; vote = 5'b00001;
    tick();
    cast = '0; vote = '0;
    tick();
    tick();
    cast = 5'b11100; vote = 5'b10100;
    tick();
    cast = '0; vote = '0;
    drain(4);

    // Same, with voter 4 missing.
    start = 1'b1;
    tick();
    start = 1'b0;
    k = cyc;
    push(5'b01011, 5'b01111, 3'd3, 1'b1, 1'b1, k + 4);
    cast = 5'b00011; vote = 5'b00011;
    tick();
    cast = '0; vote = '0;
    tick();
    tick();
    cast = 5'b01100; vote = 5'b01000;
    tick();
    cast = '0; vote = '0;
    drain(4);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vote_session_ctrl.md
# vote_session_ctrl

Sequencer for the five-voter ballot datapath. It opens a timed voting session on request and accepts at most one vote per voter. It closes the session when every voter has cast a vote or the window expires. It then presents the frozen ballot on `comps[4:0]` to the combinational vote/segment decoder and holds it there until the next session starts. Partial ballots are never exposed: `comps` stays 0 while a session is open.

## Interface
Parameters:
- `WINDOW`, default 1000: session length in clock cycles, counted from the first OPEN cycle. Legal range 1 to 2^CW−1.
- `CW`, default 16: width of the window timer.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: level sampled each cycle; opens a session when in IDLE or RESULT.
- `cast`, in, 5: per-voter cast strobe; bit i belongs to voter i.
- `vote`, in, 5: per-voter vote value (1 = yes), sampled with `cast[i]`.
- `comps`, out, 5: frozen ballot to the decoder; 0 outside RESULT.
- `voted`, out, 5: voters who have cast in the current or last session.
- `busy`, out, 1: 1 while in OPEN.
- `result_valid`, out, 1: 1 while in RESULT.
- `done`, out, 1: one-cycle pulse on the first RESULT cycle.
- `timeout`, out, 1: in RESULT, 1 if the session was closed by window expiry with `voted` != 5'b11111.
- `yes_count`, out, 3: population count of `comps`, 0..5.
- `majority`, out, 1: `yes_count` >= 3.

## Operation
- States:
  - IDLE (reset state).
  - OPEN.
  - RESULT.
- Reset (asynchronous, `rst_n`=0): state goes to IDLE. All outputs go to 0: `comps`, `voted`, `busy`, `result_valid`, `done`, `timeout`, `yes_count`, `majority`. The internal ballot register and timer are also cleared. This applies at any point, including mid-session; a session interrupted by reset is discarded.
- IDLE or RESULT with `start`=1 goes to OPEN. On that edge:
  - ballot, `voted`, `comps`, `yes_count`, `majority` and `timeout` clear to 0;
  - timer loads WINDOW−1.
- OPEN, each cycle, for every i with `cast[i]`=1 and `voted[i]`=0: `voted[i]` is set to 1 and `ballot[i]` is loaded from `vote[i]`.
  - Repeat casts from a voter who has already voted are ignored; the first vote is final.
  - Several voters may cast in the same cycle; all of them are accepted.
- OPEN close condition: (`voted` | accepted casts this cycle) == 5'b11111, OR timer == 0.
  - Casts presented in the closing cycle are accepted, including those in the timer==0 cycle.
  - On the closing edge: state goes to RESULT; `comps` ← final ballot; `yes_count`/`majority` are computed from the final ballot and registered; `done` ← 1.
  - `timeout` ← 1 only if the timer was 0 and the ballot was not complete.
  - All voters casting in the timer==0 cycle gives `timeout`=0.
- OPEN, otherwise: timer decrements by 1. `start` is ignored in OPEN.
- Voters who never cast count as "no" (ballot bit 0).
- RESULT: `comps`, `yes_count`, `majority`, `timeout` and `voted` are held. `cast` is ignored. `start` begins a new session as described above.
- `cast` is ignored in IDLE.

## Timing
- `start` sampled 1 at edge k: `busy`=1 from edge k. The first OPEN cycle (timer = WINDOW−1) can accept casts at edge k+1.
- With no completion, the session spans exactly WINDOW OPEN cycles. RESULT is entered at edge k+WINDOW.
- Completing cast sampled at edge m: `comps`, `yes_count`, `majority` and `result_valid` are valid from edge m, i.e. visible in the cycle after the cast was presented.
  - Latency from cast to result is 1 cycle.
  - `done` is high for that cycle only.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `busy` and `result_valid` are mutually exclusive; both are 0 in IDLE.
- `start` held high through RESULT re-enters OPEN on the first RESULT-sampled edge. `done` still pulses for exactly one cycle.

## Test plan
- Reset, then `start`, then one cycle later all five `cast`=1 with `vote`=5'b10110 → next cycle `comps`=5'b10110, `yes_count`=3, `majority`=1, `done`=1 for one cycle, `timeout`=0, `busy`=0.
- WINDOW=8, `start`, then only voters 0 and 2 cast with `vote`=1 → RESULT exactly 8 cycles after OPEN entry, with `comps`=5'b00101, `yes_count`=2, `majority`=0, `timeout`=1, `voted`=5'b00101.
- Voter 1 casts 1, then casts 0 three cycles later, then voters 0, 2, 3, 4 cast 0 → `comps`=5'b00010 (the repeat is ignored); `comps` reads 0 throughout OPEN.
- WINDOW=4, remaining voters cast in the timer==0 cycle so that all five have voted → votes accepted, `timeout`=0. Same run with one voter missing → `timeout`=1.
- `start` pulsed mid-OPEN → ignored, timer unchanged. `start` in RESULT → `comps`, `voted` and `yes_count` clear on the next edge and `busy`=1.
- `rst_n` asserted asynchronously two cycles into OPEN after three casts → all outputs 0 immediately. After release, IDLE ignores `cast`=5'b11111.
